id_ex_operand_stage: RTL and testbench

Decode-to-execute pipeline register plus execute-stage operand selection for the 5-stage MIPS-style core. Captures decoded operands and control at the ID/EX boundary. Applies hazard-unit forwarding selects and the ALUSrc immediate mux. Drives SrcAE, SrcBE and ALUControlE straight into the ALU, and passes write-data and destination-register information on toward EX/MEM.

---
 rtl/id_ex_operand_stage.sv | 101 ++++++++++
 tb/tb_id_ex_operand_stage.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/id_ex_operand_stage.sv
// rtl/id_ex_operand_stage.sv - ID/EX pipeline register with forwarding and ALUSrc operand muxing
module id_ex_operand_stage #(
    parameter int WIDTH   = 32,
    parameter int REGBITS = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               StallE,
    input  logic               FlushE,
    input  logic [WIDTH-1:0]   RD1D,
    input  logic [WIDTH-1:0]   RD2D,
    input  logic [WIDTH-1:0]   SignImmD,
    input  logic [REGBITS-1:0] RsD,
    input  logic [REGBITS-1:0] RtD,
    input  logic [REGBITS-1:0] RdD,
    input  logic [2:0]         ALUControlD,
    input  logic               ALUSrcD,
    input  logic               RegDstD,
    input  logic               RegWriteD,
    input  logic               MemtoRegD,
    input  logic               MemWriteD,
    input  logic [WIDTH-1:0]   ALUOutM,
    input  logic [WIDTH-1:0]   ResultW,
    input  logic [1:0]         ForwardAE,
    input  logic [1:0]         ForwardBE,
    output logic [WIDTH-1:0]   SrcAE,
    output logic [WIDTH-1:0]   SrcBE,
    output logic [2:0]         ALUControlE,
    output logic [WIDTH-1:0]   WriteDataE,
    output logic [REGBITS-1:0] WriteRegE,
    output logic [REGBITS-1:0] RsE,
    output logic [REGBITS-1:0] RtE,
    output logic               RegWriteE,
    output logic               MemtoRegE,
    output logic               MemWriteE,
    output logic               ValidE
);

    logic [WIDTH-1:0]   RD1E;
    logic [WIDTH-1:0]   RD2E;
    logic [WIDTH-1:0]   SignImmE;
    logic [REGBITS-1:0] RdE;
    logic               ALUSrcE;
    logic               RegDstE;

    // A flush is indistinguishable from reset and overrides a simultaneous stall.
    always_ff @(posedge clk) begin
        if (reset || FlushE) begin
            RD1E        <= '0;
            RD2E        <= '0;
            SignImmE    <= '0;
            RsE         <= '0;
            RtE         <= '0;
            RdE         <= '0;
            ALUControlE <= '0;
            ALUSrcE     <= 1'b0;
            RegDstE     <= 1'b0;
            RegWriteE   <= 1'b0;
            MemtoRegE   <= 1'b0;
            MemWriteE   <= 1'b0;
            ValidE      <= 1'b0;
        end else if (!StallE) begin
            RD1E        <= RD1D;
            RD2E        <= RD2D;
            SignImmE    <= SignImmD;
            RsE         <= RsD;
            RtE         <= RtD;
            RdE         <= RdD;
            ALUControlE <= ALUControlD;
            ALUSrcE     <= ALUSrcD;
            RegDstE     <= RegDstD;
            RegWriteE   <= RegWriteD;
            MemtoRegE   <= MemtoRegD;
            MemWriteE   <= MemWriteD;
            ValidE      <= 1'b1;
        end
    end

    // Forwarding stays live while stalled so a held instruction sees fresh bypass data.
    always_comb begin
        SrcAE = RD1E;
        case (ForwardAE)
            2'b01:   SrcAE = ResultW;
            2'b10:   SrcAE = ALUOutM;
            default: SrcAE = RD1E;
        endcase
    end

    always_comb begin
        WriteDataE = RD2E;
        case (ForwardBE)
            2'b01:   WriteDataE = ResultW;
            2'b10:   WriteDataE = ALUOutM;
            default: WriteDataE = RD2E;
        endcase
    end

    assign SrcBE     = ALUSrcE ? SignImmE : WriteDataE;
    assign WriteRegE = RegDstE ? RdE : RtE;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// tb/tb_id_ex_operand_stage.sv - directed self-checking bench for id_ex_operand_stage
module tb_id_ex_operand_stage;

    localparam int WIDTH   = 32;
    localparam int REGBITS = 5;

    logic               clk = 1'b0;
    logic               reset;
    logic               StallE;
    logic               FlushE;
    logic [WIDTH-1:0]   RD1D;
    logic [WIDTH-1:0]   RD2D;
    logic [WIDTH-1:0]   SignImmD;
    logic [REGBITS-1:0] RsD;
    logic [REGBITS-1:0] RtD;
    logic [REGBITS-1:0] RdD;
    logic [2:0]         ALUControlD;
    logic               ALUSrcD;
    logic               RegDstD;
    logic               RegWriteD;
    logic               MemtoRegD;
    logic               MemWriteD;
    logic [WIDTH-1:0]   ALUOutM;
    logic [WIDTH-1:0]   ResultW;
    logic [1:0]         ForwardAE;
    logic [1:0]         ForwardBE;
    logic [WIDTH-1:0]   SrcAE;
    logic [WIDTH-1:0]   SrcBE;
    logic [2:0]         ALUControlE;
    logic [WIDTH-1:0]   WriteDataE;
    logic [REGBITS-1:0] WriteRegE;
    logic [REGBITS-1:0] RsE;
    logic [REGBITS-1:0] RtE;
    logic               RegWriteE;
    logic               MemtoRegE;
    logic               MemWriteE;
    logic               ValidE;

    int testsRun  = 0;
    int failCount = 0;

    id_ex_operand_stage #(.WIDTH(WIDTH), .REGBITS(REGBITS)) dut (
        .clk(clk), .reset(reset), .StallE(StallE), .FlushE(FlushE),
        .RD1D(RD1D), .RD2D(RD2D), .SignImmD(SignImmD),
        .RsD(RsD), .RtD(RtD), .RdD(RdD),
        .ALUControlD(ALUControlD), .ALUSrcD(ALUSrcD), .RegDstD(RegDstD),
        .RegWriteD(RegWriteD), .MemtoRegD(MemtoRegD), .MemWriteD(MemWriteD),
        .ALUOutM(ALUOutM), .ResultW(ResultW),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .SrcAE(SrcAE), .SrcBE(SrcBE), .ALUControlE(ALUControlE),
        .WriteDataE(WriteDataE), .WriteRegE(WriteRegE),
        .RsE(RsE), .RtE(RtE),
        .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .MemWriteE(MemWriteE),
        .ValidE(ValidE)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkCleared(input string tag);
        check({tag, ".SrcAE"},       SrcAE,       32'h0);
        check({tag, ".SrcBE"},       SrcBE,       32'h0);
        check({tag, ".WriteDataE"},  WriteDataE,  32'h0);
        check({tag, ".ALUControlE"}, 32'(ALUControlE), 32'h0);
        check({tag, ".WriteRegE"},   32'(WriteRegE),   32'h0);
        check({tag, ".RsE"},         32'(RsE),         32'h0);
        check({tag, ".RtE"},         32'(RtE),         32'h0);
        check({tag, ".RegWriteE"},   32'(RegWriteE),   32'h0);
        check({tag, ".MemtoRegE"},   32'(MemtoRegE),   32'h0);
        check({tag, ".MemWriteE"},   32'(MemWriteE),   32'h0);
        check({tag, ".ValidE"},      32'(ValidE),      32'h0);
    endtask

    initial begin
        reset = 1'b1; StallE = 1'b0; FlushE = 1'b0;
        RD1D = 32'hDEAD0001; RD2D = 32'hDEAD0002; SignImmD = 32'hDEAD0003;
        RsD = 5'd1; RtD = 5'd2; RdD = 5'd3; ALUControlD = 3'd7;
        ALUSrcD = 1'b1; RegDstD = 1'b1; RegWriteD = 1'b1; MemtoRegD = 1'b1; MemWriteD = 1'b1;
        ALUOutM = 32'h0; ResultW = 32'h0; ForwardAE = 2'b00; ForwardBE = 2'b00;
        tick();
        checkCleared("reset");

        // Basic load
        reset = 1'b0;
        RD1D = 32'd5; RD2D = 32'd3; SignImmD = 32'd0; ALUControlD = 3'd1; ALUSrcD = 1'b0;
        RsD = 5'd9; RtD = 5'd8; RdD = 5'd12; RegDstD = 1'b0;
        RegWriteD = 1'b1; MemtoRegD = 1'b1; MemWriteD = 1'b0;
        tick();
        check("load.SrcAE", SrcAE, 32'd5);
        check("load.SrcBE", SrcBE, 32'd3);
        check("load.ALUControlE", 32'(ALUControlE), 32'd1);
        check("load.ValidE", 32'(ValidE), 32'd1);
        check("load.RegWriteE", 32'(RegWriteE), 32'd1);
        check("load.MemtoRegE", 32'(MemtoRegE), 32'd1);
        check("load.RsE", 32'(RsE), 32'd9);
        check("load.RtE", 32'(RtE), 32'd8);

        // Immediate operand, store data still forwarded rt
        ALUSrcD = 1'b1; SignImmD = 32'hFFFFFFFC; RD2D = 32'd7; MemWriteD = 1'b1;
        tick();
        check("imm.SrcBE", SrcBE, 32'hFFFFFFFC);
        check("imm.WriteDataE", WriteDataE, 32'd7);
        check("imm.MemWriteE", 32'(MemWriteE), 32'd1);

        // Forwarding selects
        RD1D = 32'd1; RD2D = 32'd2; ALUSrcD = 1'b0; MemWriteD = 1'b0;
        ALUOutM = 32'd9; ResultW = 32'd4;
        tick();
        ForwardAE = 2'b10; #1; check("fwdA10", SrcAE, 32'd9);
        ForwardAE = 2'b01; #1; check("fwdA01", SrcAE, 32'd4);
        ForwardAE = 2'b11; #1; check("fwdA11", SrcAE, 32'd1);
        ForwardAE = 2'b00; #1; check("fwdA00", SrcAE, 32'd1);
        ForwardBE = 2'b10; #1; check("fwdB10.WriteDataE", WriteDataE, 32'd9);
        check("fwdB10.SrcBE", SrcBE, 32'd9);
        ForwardBE = 2'b01; #1; check("fwdB01.WriteDataE", WriteDataE, 32'd4);
        ForwardBE = 2'b11; #1; check("fwdB11.WriteDataE", WriteDataE, 32'd2);
        ForwardBE = 2'b00;

        // Stall holds for three cycles while D changes
        RD1D = 32'h11; RD2D = 32'h22; ALUControlD = 3'd2; RsD = 5'd3; RtD = 5'd4; RdD = 5'd5;
        RegDstD = 1'b1; RegWriteD = 1'b0; MemWriteD = 1'b1;
        tick();
        StallE = 1'b1;
        for (int i = 0; i < 3; i++) begin
            RD1D = 32'hA0 + 32'(i); RD2D = 32'hB0 + 32'(i); ALUControlD = 3'd6;
            RsD = 5'd20; RtD = 5'd21; RdD = 5'd22; RegDstD = 1'b0; MemWriteD = 1'b0;
            tick();
            check("stall.SrcAE", SrcAE, 32'h11);
            check("stall.SrcBE", SrcBE, 32'h22);
            check("stall.ALUControlE", 32'(ALUControlE), 32'd2);
            check("stall.RsE", 32'(RsE), 32'd3);
            check("stall.WriteRegE", 32'(WriteRegE), 32'd5);
            check("stall.MemWriteE", 32'(MemWriteE), 32'd1);
            check("stall.ValidE", 32'(ValidE), 32'd1);
        end
        ForwardAE = 2'b10; #1; check("stall.fwdA10", SrcAE, 32'd9);
        ForwardAE = 2'b00;

        // Flush beats stall
        FlushE = 1'b1; RegWriteD = 1'b1; MemWriteD = 1'b1; ALUControlD = 3'd5;
        tick();
        check("flush.ValidE", 32'(ValidE), 32'd0);
        check("flush.RegWriteE", 32'(RegWriteE), 32'd0);
        check("flush.MemWriteE", 32'(MemWriteE), 32'd0);
        check("flush.ALUControlE", 32'(ALUControlE), 32'd0);
        check("flush.SrcAE", SrcAE, 32'd0);

        // Reload, then reset during a stall
        FlushE = 1'b0; StallE = 1'b0;
        RD1D = 32'h55; RD2D = 32'h66; SignImmD = 32'h77; ALUSrcD = 1'b1; RegDstD = 1'b1;
        tick();
        check("reload.ValidE", 32'(ValidE), 32'd1);
        check("reload.SrcBE", SrcBE, 32'h77);
        StallE = 1'b1; reset = 1'b1;
        tick();
        checkCleared("rststall");
        reset = 1'b0; StallE = 1'b0;

        // Destination register select
        RegDstD = 1'b1; RdD = 5'd12; RtD = 5'd8;
        tick();
        check("regdst1.WriteRegE", 32'(WriteRegE), 32'd12);
        RegDstD = 1'b0;
        tick();
        check("regdst0.WriteRegE", 32'(WriteRegE), 32'd8);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
